// File: rtl/bsg_fpu_preprocess_norm.sv
// rtl/bsg_fpu_preprocess_norm.sv - registered IEEE-754 operand unpacker with iterative denormal normalisation
//
// Purpose:
//   Accepts one packed floating-point operand and classifies it.
//   The class flags are zero, NaN, signalling NaN, infinity and denormal.
//   It presents the operand with an explicit leading mantissa bit and a signed biased exponent.
//   Denormal operands are left-shifted one bit per cycle until the leading one reaches bit m_p.
//   The exponent is decremented on every shift, so downstream units never see a hidden bit.
//
// Ports:
//   clk_i       clock
//   reset_n_i   asynchronous active-low reset
//   v_i         operand valid (held by the producer until taken)
//   a_i         packed operand {sign, exp[e_p-1:0], man[m_p-1:0]}
//   ready_o     block is idle and will take v_i on the next edge
//   v_o         result valid; outputs are stable until yumi_i
//   yumi_i      consumer takes the result (only meaningful while v_o=1)
//   sign_o      operand sign
//   exp_o       signed biased exponent after normalisation (e_p+2 bits, two's complement)
//   man_o       mantissa with explicit leading bit (m_p+1 bits)
//   zero_o, nan_o, sig_nan_o, infty_o, denormal_o
//               class flags of the original operand

module bsg_fpu_preprocess_norm #(
   parameter int e_p = 5,
   parameter int m_p = 10
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               v_i,
   input  logic [e_p+m_p:0]   a_i,
   output logic               ready_o,
   output logic               v_o,
   input  logic               yumi_i,
   output logic               sign_o,
   output logic [e_p+1:0]     exp_o,
   output logic [m_p:0]       man_o,
   output logic               zero_o,
   output logic               nan_o,
   output logic               sig_nan_o,
   output logic               infty_o,
   output logic               denormal_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [e_p+1:0] exp_one = (e_p+2)'(1);

   state_t state_r, state_n;

   // Field split of the incoming operand.
   logic             a_sign;
   logic [e_p-1:0]   a_exp;
   logic [m_p-1:0]   a_man;
   assign a_sign = a_i[e_p+m_p];
   assign a_exp  = a_i[e_p+m_p-1:m_p];
   assign a_man  = a_i[m_p-1:0];

   // Combinational classification of the incoming operand.
   logic exp_zero, exp_ones, man_zero;
   logic c_zero, c_nan, c_sig_nan, c_infty, c_denormal;
   assign exp_zero   = (a_exp == '0);
   assign exp_ones   = &a_exp;
   assign man_zero   = (a_man == '0);
   assign c_zero     = exp_zero & man_zero;
   assign c_denormal = exp_zero & ~man_zero;
   assign c_nan      = exp_ones & ~man_zero;
   // A NaN is signalling when the top stored mantissa bit (the quiet bit) is clear.
   assign c_sig_nan  = c_nan & ~a_man[m_p-1];
   assign c_infty    = exp_ones & man_zero;

   logic accept;
   assign accept = v_i & (state_r == IDLE);

   logic               sign_r;
   logic [e_p+1:0]     exp_r;
   logic [m_p:0]       man_r;
   logic               zero_r, nan_r, sig_nan_r, infty_r, denormal_r;

   // State register
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Next-state logic
   always_comb begin
      state_n = state_r;
      case (state_r)
         IDLE: begin
            if (v_i) begin
               state_n = c_denormal ? NORM : DONE;
            end
         end
         // The shift about to happen moves bit m_p-1 into bit m_p, which completes normalisation.
         NORM: begin
            if (man_r[m_p-1]) begin
               state_n = DONE;
            end
         end
         DONE: begin
            if (yumi_i) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Handshake outputs decode only the state register.
   always_comb begin
      ready_o = (state_r == IDLE);
      v_o     = (state_r == DONE);
   end

   // Datapath registers
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         sign_r     <= 1'b0;
         exp_r      <= '0;
         man_r      <= '0;
         zero_r     <= 1'b0;
         nan_r      <= 1'b0;
         sig_nan_r  <= 1'b0;
         infty_r    <= 1'b0;
         denormal_r <= 1'b0;
      end else if (accept) begin
         sign_r     <= a_sign;
         zero_r     <= c_zero;
         nan_r      <= c_nan;
         sig_nan_r  <= c_sig_nan;
         infty_r    <= c_infty;
         denormal_r <= c_denormal;
         if (c_zero) begin
            exp_r <= '0;
            man_r <= '0;
         end else if (c_denormal) begin
            // A denormal has the same scale as exponent 1 without the hidden bit.
            exp_r <= exp_one;
            man_r <= {1'b0, a_man};
         end else begin
            exp_r <= {2'b00, a_exp};
            man_r <= {1'b1, a_man};
         end
      end else if (state_r == NORM) begin
         man_r <= man_r << 1;
         exp_r <= exp_r - exp_one;
      end
   end

   assign sign_o     = sign_r;
   assign exp_o      = exp_r;
   assign man_o      = man_r;
   assign zero_o     = zero_r;
   assign nan_o      = nan_r;
   assign sig_nan_o  = sig_nan_r;
   assign infty_o    = infty_r;
   assign denormal_o = denormal_r;

endmodule

// File: tb/tb_bsg_fpu_preprocess_norm.sv
// tb/tb_bsg_fpu_preprocess_norm.sv - self-checking bench for bsg_fpu_preprocess_norm

module tb_bsg_fpu_preprocess_norm;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        v_i = 1'b0;
   logic [15:0] a_i = '0;
   logic        ready_o, v_o;
   logic        yumi_i = 1'b0;
   logic        sign_o;
   logic [6:0]  exp_o;
   logic [10:0] man_o;
   logic        zero_o, nan_o, sig_nan_o, infty_o, denormal_o;

   int total = 0;
   int bad = 0;

   bsg_fpu_preprocess_norm #(.e_p(5), .m_p(10)) dut (
      .clk_i      (clk),
      .reset_n_i  (reset_n),
      .v_i        (v_i),
      .a_i        (a_i),
      .ready_o    (ready_o),
      .v_o        (v_o),
      .yumi_i     (yumi_i),
      .sign_o     (sign_o),
      .exp_o      (exp_o),
      .man_o      (man_o),
      .zero_o     (zero_o),
      .nan_o      (nan_o),
      .sig_nan_o  (sig_nan_o),
      .infty_o    (infty_o),
      .denormal_o (denormal_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic logic [4:0] flags();
      return {zero_o, nan_o, sig_nan_o, infty_o, denormal_o};
   endfunction

   // Reference unpacker: {zero,nan,sig_nan,infty,denormal} flags and latency.
   task automatic ref_model(input logic [15:0] a, output logic s, output logic [6:0] e,
                            output logic [10:0] m, output logic [4:0] fl, output int lat);
      logic [4:0] ef;
      logic [9:0] mf;
      int p;
      int sh;
      ef = a[14:10];
      mf = a[9:0];
      s = a[15];
      lat = 1;
      fl = '0;
      if (ef == 5'd0 && mf == 10'd0) begin
         e = '0; m = '0; fl[4] = 1'b1;
      end else if (ef == 5'd0) begin
         p = 0;
         for (int i = 0; i < 10; i++) if (mf[i]) p = i;
         sh = 10 - p;
         m = 11'({1'b0, mf} << sh);
         e = 7'(1 - sh);
         lat = 1 + sh;
         fl[0] = 1'b1;
      end else begin
         e = {2'b00, ef};
         m = {1'b1, mf};
         if (ef == 5'h1F) begin
            fl[3] = (mf != 0);
            fl[2] = (mf != 0) && !mf[9];
            fl[1] = (mf == 0);
         end
      end
   endtask

   // Presents a, waits for the accept edge, then counts cycles until v_o (bounded).
   task automatic start_op(input logic [15:0] a, output int lat);
      check("ready_before", ready_o, 1'b1);
      v_i = 1'b1;
      a_i = a;
      @(posedge clk); #1;
      v_i = 1'b0;
      lat = 1;
      while (!v_o && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("v_o_timeout", v_o, 1'b1);
   endtask

   task automatic finish_op();
      yumi_i = 1'b1;
      @(posedge clk); #1;
      yumi_i = 1'b0;
      check("ready_after_yumi", ready_o, 1'b1);
      check("v_o_after_yumi", v_o, 1'b0);
   endtask

   typedef struct {
      logic [15:0] a;
      logic        s;
      logic [6:0]  e;
      logic [10:0] m;
      logic [4:0]  fl;
      int          lat;
   } vec_t;

   vec_t vecs[9] = '{
      '{16'h3C00, 1'b0, 7'h0F, 11'h400, 5'b00000, 1},
      '{16'h0001, 1'b0, 7'h77, 11'h400, 5'b00001, 11},
      '{16'h0200, 1'b0, 7'h00, 11'h400, 5'b00001, 2},
      '{16'h03FF, 1'b0, 7'h00, 11'h7FE, 5'b00001, 2},
      '{16'h8000, 1'b1, 7'h00, 11'h000, 5'b10000, 1},
      '{16'hFC00, 1'b1, 7'h1F, 11'h400, 5'b00010, 1},
      '{16'h7E00, 1'b0, 7'h1F, 11'h600, 5'b01000, 1},
      '{16'h7D00, 1'b0, 7'h1F, 11'h500, 5'b01100, 1},
      '{16'h7BFF, 1'b0, 7'h1E, 11'h7FF, 5'b00000, 1}
   };

   initial begin
      int lat;
      logic s;
      logic [6:0] e;
      logic [10:0] m;
      logic [4:0] fl;
      int rlat;
      logic [15:0] a;

      // Reset state
      #2;
      check("rst_v_o", v_o, 1'b0);
      check("rst_ready", ready_o, 1'b1);
      check("rst_data", {sign_o, exp_o, man_o, flags()}, 24'h0);
      #10 reset_n = 1'b1;
      @(posedge clk); #1;

      // yumi_i while idle is ignored
      yumi_i = 1'b1;
      @(posedge clk); #1;
      yumi_i = 1'b0;
      check("idle_yumi_ready", ready_o, 1'b1);
      check("idle_yumi_v_o", v_o, 1'b0);

      // Directed vectors
      foreach (vecs[i]) begin
         start_op(vecs[i].a, lat);
         check($sformatf("lat_%h", vecs[i].a), lat, vecs[i].lat);
         check($sformatf("sign_%h", vecs[i].a), sign_o, vecs[i].s);
         check($sformatf("exp_%h", vecs[i].a), exp_o, vecs[i].e);
         check($sformatf("man_%h", vecs[i].a), man_o, vecs[i].m);
         check($sformatf("flags_%h", vecs[i].a), flags(), vecs[i].fl);
         finish_op();
      end

      // Backpressure: result held while a second operand waits on v_i
      start_op(16'h3C00, lat);
      v_i = 1'b1;
      a_i = 16'h4000;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("bp_v_o", v_o, 1'b1);
         check("bp_ready", ready_o, 1'b0);
         check("bp_hold", {sign_o, exp_o, man_o, flags()}, {1'b0, 7'h0F, 11'h400, 5'b0});
      end
      yumi_i = 1'b1;
      @(posedge clk); #1;
      yumi_i = 1'b0;
      check("bp_idle_ready", ready_o, 1'b1);
      check("bp_idle_v_o", v_o, 1'b0);
      @(posedge clk); #1;
      v_i = 1'b0;
      check("bp_second_v_o", v_o, 1'b1);
      check("bp_second_exp", exp_o, 7'h10);
      check("bp_second_man", man_o, 11'h400);
      finish_op();

      // Asynchronous reset in the middle of normalisation
      v_i = 1'b1;
      a_i = 16'h0001;
      @(posedge clk); #1;
      v_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("mid_norm_v_o", v_o, 1'b0);
      reset_n = 1'b0;
      #1;
      check("arst_v_o", v_o, 1'b0);
      check("arst_ready", ready_o, 1'b1);
      check("arst_data", {sign_o, exp_o, man_o, flags()}, 24'h0);
      #4 reset_n = 1'b1;
      @(posedge clk); #1;
      start_op(16'h3C00, lat);
      check("post_rst_lat", lat, 1);
      check("post_rst_exp", exp_o, 7'h0F);
      check("post_rst_man", man_o, 11'h400);
      finish_op();

      // Sweep: every denormal/zero pattern plus random operands against the model
      for (int i = 0; i < 3000; i++) begin
         if (i < 1024) a = 16'(i) | (i[0] ? 16'h8000 : 16'h0000);
         else a = 16'($urandom_range(0, 65535));
         ref_model(a, s, e, m, fl, rlat);
         start_op(a, lat);
         check("sw_lat", lat, rlat);
         check("sw_out", {sign_o, exp_o, man_o, flags()}, {s, e, m, fl});
         if (a[14:0] != 15'd0) check("sw_lead", man_o[10], 1'b1);
         finish_op();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
